// File: rtl/bit_deserializer_if.sv
// Stream and word-output port bundle for bit_deserializer.
// The slave modport is the deserializer; the master modport is the bit source and word consumer.
interface bit_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             d;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output en, d, dout_ready,
        input  dout, dout_valid, busy, overrun, parity_err
    );

    modport slave (
        input  en, d, dout_ready,
        output dout, dout_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/bit_deserializer.sv
// Collects strobed serial bits into WIDTH-bit words and offers them on a valid/ready port.
// Optional feature macro: PARITY_CHECK_EN (one trailing even-parity bit per word).
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    bit_deserializer_if.slave  bus
);

`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int             CW   = $clog2(NBITS + 1);
    localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;
    logic             r_parity_err;
    logic             w_parity;
    logic             w_complete;
    logic             w_load;
    logic             w_accept;

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_state_next = ST_SHIFT;
                    w_count_next = CW'(1);
                end
            end
            ST_SHIFT: begin
                if (bus.en) begin
                    if (r_count == LAST) begin
                        w_complete   = 1'b1;
                        w_state_next = ST_IDLE;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], bus.d}
                                    : {bus.d, r_shift[WIDTH-1:1]};

`ifdef PARITY_CHECK_EN
    // The completing strobe carries the parity bit; the data bits are already in r_shift.
    assign w_word   = r_shift;
    assign w_parity = (^r_shift) ^ bus.d;
`else
    // The completing strobe carries the last data bit, so the word includes it directly.
    assign w_word   = w_shift_next;
    assign w_parity = 1'b0;
`endif

    assign w_accept = r_valid & bus.dout_ready;
    assign w_load   = w_complete & (~r_valid | bus.dout_ready);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_busy  <= (w_count_next != '0);
            if (bus.en) begin
                r_shift <= w_shift_next;
            end
            // A completion with the held word not taken drops the new word.
            if (w_load) begin
                r_dout       <= w_word;
                r_valid      <= 1'b1;
                r_parity_err <= w_parity;
            end else if (w_complete) begin
                r_overrun    <= 1'b1;
            end else if (w_accept) begin
                r_valid      <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;
    assign bus.parity_err = r_parity_err;

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer: MSB-first and LSB-first instances, scoreboarded accepts.
module tb_bit_deserializer;

    typedef struct {
        logic [7:0] word;
        bit         gap;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bit_deserializer_if #(.WIDTH(8)) m_if ();
    bit_deserializer_if #(.WIDTH(8)) l_if ();

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (l_if)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        m_if.en = 1'b1;
        m_if.d  = b;
        tick();
        m_if.en = 1'b0;
    endtask

    task automatic send_bit_l(input logic b);
        l_if.en = 1'b1;
        l_if.d  = b;
        tick();
        l_if.en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (gap) tick();
        end
`ifdef PARITY_CHECK_EN
        send_bit(^w);
`endif
    endtask

    task automatic ready_pulse();
        m_if.dout_ready = 1'b1;
        tick();
        m_if.dout_ready = 1'b0;
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && m_if.dout_valid && m_if.dout_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_accept: got=%0h expected=none", m_if.dout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("accept_word", {24'h0, m_if.dout}, {24'h0, mon_exp});
            end
        end
    end

    initial begin
        logic [7:0] w;
        logic [7:0] lsb_bits;

        vecs[0] = '{word: 8'h55, gap: 1'b0, exp_dout: 8'h55};
        vecs[1] = '{word: 8'hAA, gap: 1'b0, exp_dout: 8'hAA};
        vecs[2] = '{word: 8'h00, gap: 1'b0, exp_dout: 8'h00};
        vecs[3] = '{word: 8'hFF, gap: 1'b1, exp_dout: 8'hFF};
        vecs[4] = '{word: 8'h81, gap: 1'b0, exp_dout: 8'h81};
        vecs[5] = '{word: 8'h7E, gap: 1'b1, exp_dout: 8'h7E};

        reset = 1'b1;
        m_if.en = 1'b0; m_if.d = 1'b0; m_if.dout_ready = 1'b0;
        l_if.en = 1'b0; l_if.d = 1'b0; l_if.dout_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_dout",    m_if.dout,       0);
        check("rst_valid",   m_if.dout_valid, 0);
        check("rst_busy",    m_if.busy,       0);
        check("rst_overrun", m_if.overrun,    0);
        check("rst_parity",  m_if.parity_err, 0);
        reset = 1'b0;

        // A5 held with ready low
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        check("a5_busy_mid",  m_if.busy,       1);
        check("a5_valid_mid", m_if.dout_valid, 0);
        send_bit(w[0]);
`ifdef PARITY_CHECK_EN
        check("a5_wait_parity", m_if.dout_valid, 0);
        send_bit(^w);
`endif
        check("a5_valid", m_if.dout_valid, 1);
        check("a5_dout",  m_if.dout,       8'hA5);
        check("a5_busy",  m_if.busy,       0);
        check("a5_perr",  m_if.parity_err, 0);
        repeat (3) tick();
        check("a5_held_valid", m_if.dout_valid, 1);
        check("a5_held_dout",  m_if.dout,       8'hA5);
        exp_q.push_back(8'hA5);
        ready_pulse();
        check("a5_accept_valid", m_if.dout_valid, 0);
        check("a5_accept_dout",  m_if.dout,       8'hA5);

        // 3C with en on alternate cycles
        send_word(8'h3C, 1'b1);
        check("3c_dout",  m_if.dout,       8'h3C);
        check("3c_valid", m_if.dout_valid, 1);
        exp_q.push_back(8'h3C);
        ready_pulse();
        check("3c_accept_valid", m_if.dout_valid, 0);

        // Table: ready held high, back-to-back and gapped words
        m_if.dout_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(vecs[k].exp_dout);
            send_word(vecs[k].word, vecs[k].gap);
        end
        tick();
        tick();
        m_if.dout_ready = 1'b0;
        check("tbl_valid",   m_if.dout_valid, 0);
        check("tbl_overrun", m_if.overrun,    0);
        check("tbl_drained", exp_q.size(),    0);

        // Completion on the same edge as an accept
        exp_q.push_back(8'h12);
        send_word(8'h12, 1'b0);
        check("same_first_valid", m_if.dout_valid, 1);
        exp_q.push_back(8'h34);
        w = 8'h34;
`ifdef PARITY_CHECK_EN
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        m_if.dout_ready = 1'b1;
        send_bit(^w);
`else
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        m_if.dout_ready = 1'b1;
        send_bit(w[0]);
`endif
        check("same_dout",    m_if.dout,       8'h34);
        check("same_valid",   m_if.dout_valid, 1);
        check("same_overrun", m_if.overrun,    0);
        tick();
        m_if.dout_ready = 1'b0;
        check("same_drain_valid", m_if.dout_valid, 0);

        // Overrun: second word dropped while first is held
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        check("ovr_dout",    m_if.dout,       8'h11);
        check("ovr_valid",   m_if.dout_valid, 1);
        check("ovr_flag",    m_if.overrun,    1);
        exp_q.push_back(8'h11);
        ready_pulse();
        check("ovr_accept_valid", m_if.dout_valid, 0);
        tick();
        check("ovr_sticky", m_if.overrun, 1);

        // Reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("mid_busy", m_if.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy",    m_if.busy,       0);
        check("mid_rst_overrun", m_if.overrun,    0);
        check("mid_rst_valid",   m_if.dout_valid, 0);
        check("mid_rst_dout",    m_if.dout,       0);
        send_word(8'h0F, 1'b0);
        check("mid_dout",  m_if.dout,       8'h0F);
        check("mid_valid", m_if.dout_valid, 1);
        check("mid_busy_after", m_if.busy,  0);
        exp_q.push_back(8'h0F);
        ready_pulse();

        // LSB-first instance: bits 1,1,1,1,0,0,0,0 -> 0F
        lsb_bits = 8'b1111_0000;
        for (int i = 7; i >= 0; i--) send_bit_l(lsb_bits[i]);
`ifdef PARITY_CHECK_EN
        send_bit_l(1'b0);
`endif
        check("lsb_dout",  l_if.dout,       8'h0F);
        check("lsb_valid", l_if.dout_valid, 1);

`ifdef PARITY_CHECK_EN
        // Bad parity: A5 with pbit=1 is still delivered, flagged
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        send_bit(1'b1);
        check("par_dout",  m_if.dout,       8'hA5);
        check("par_valid", m_if.dout_valid, 1);
        check("par_err",   m_if.parity_err, 1);
        exp_q.push_back(8'hA5);
        ready_pulse();
`endif

        tick();
        check("final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
